// File: rtl/seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : seven_seg_scan_decoder
// Description : Rebuilds the four BCD digits shown on a scanned 7-segment bus.
// Revision    : 1.0 - initial release
// ============================================================================
module seven_seg_scan_decoder #(
    parameter int STABLE_CYCLES = 4,
    parameter bit SEG_ACT_LOW   = 1'b1,
    parameter bit SEL_ACT_LOW   = 1'b1
) (
    input  logic       clk,
    input  logic       rst,
    input  logic [6:0] sevenout,
    input  logic [3:0] seven_select,
    output logic [3:0] digit1,
    output logic [3:0] digit2,
    output logic [3:0] digit3,
    output logic [3:0] digit4,
    output logic       frame_valid,
    output logic       seg_err,
    output logic       sel_err
);

    localparam int                 c_CNT_W   = $clog2(STABLE_CYCLES + 1);
    localparam logic [c_CNT_W-1:0] c_CNT_MAX = c_CNT_W'(STABLE_CYCLES);

    typedef enum logic [1:0] {
        ST_IDLE  = 2'd0,
        ST_COUNT = 2'd1,
        ST_HOLD  = 2'd2
    } state_t;

    state_t             r_state;
    state_t             w_state_next;
    logic [6:0]         r_s_seg;
    logic [3:0]         r_s_sel;
    logic [6:0]         r_p_seg;
    logic [3:0]         r_p_sel;
    logic [c_CNT_W-1:0] r_cnt;
    logic [c_CNT_W-1:0] w_cnt_next;
    logic [3:0]         r_shadow [4];
    logic [3:0]         r_mask;
    logic [3:0]         w_mask_new;
    logic [3:0]         w_dec;
    logic               w_changed;
    logic               w_sel_none;
    logic               w_sel_one;
    logic               w_capture;

    assign w_changed  = {r_s_seg, r_s_sel} != {r_p_seg, r_p_sel};
    assign w_sel_none = (r_s_sel == 4'd0);
    assign w_sel_one  = $onehot(r_s_sel);
    assign w_mask_new = r_mask | r_s_sel;

    always_comb begin
        w_cnt_next = r_cnt;
        if (w_changed) begin
            w_cnt_next = c_CNT_W'(1);
        end else if (r_cnt != c_CNT_MAX) begin
            w_cnt_next = r_cnt + c_CNT_W'(1);
        end
    end

    // Segment patterns are active-high {g,f,e,d,c,b,a} here.
    always_comb begin
        case (r_s_seg)
            7'h3F:   w_dec = 4'd0;
            7'h06:   w_dec = 4'd1;
            7'h5B:   w_dec = 4'd2;
            7'h4F:   w_dec = 4'd3;
            7'h66:   w_dec = 4'd4;
            7'h6D:   w_dec = 4'd5;
            7'h7D:   w_dec = 4'd6;
            7'h07:   w_dec = 4'd7;
            7'h7F:   w_dec = 4'd8;
            7'h6F:   w_dec = 4'd9;
            7'h00:   w_dec = 4'hF;
            default: w_dec = 4'hE;
        endcase
    end

    always_comb begin
        w_state_next = r_state;
        w_capture    = 1'b0;
        case (r_state)
            ST_IDLE: begin
                if (!w_sel_none) w_state_next = ST_COUNT;
            end
            ST_COUNT: begin
                if (w_changed) begin
                    w_state_next = w_sel_none ? ST_IDLE : ST_COUNT;
                end else if (w_cnt_next == c_CNT_MAX) begin
                    w_capture    = 1'b1;
                    w_state_next = ST_HOLD;
                end
            end
            ST_HOLD: begin
                if (w_changed) w_state_next = w_sel_none ? ST_IDLE : ST_COUNT;
            end
            default: w_state_next = ST_IDLE;
        endcase
    end

    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            r_state <= ST_IDLE;
            r_s_seg <= 7'd0;
            r_s_sel <= 4'd0;
            r_p_seg <= 7'd0;
            r_p_sel <= 4'd0;
            r_cnt   <= '0;
        end else begin
            r_state <= w_state_next;
            r_s_seg <= SEG_ACT_LOW ? ~sevenout : sevenout;
            r_s_sel <= SEL_ACT_LOW ? ~seven_select : seven_select;
            r_p_seg <= r_s_seg;
            r_p_sel <= r_s_sel;
            r_cnt   <= w_cnt_next;
        end
    end

    // The completing digit bypasses the shadow so the frame carries it on the same edge.
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            for (int i = 0; i < 4; i++) r_shadow[i] <= 4'hF;
            r_mask      <= 4'd0;
            digit1      <= 4'hF;
            digit2      <= 4'hF;
            digit3      <= 4'hF;
            digit4      <= 4'hF;
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            sel_err     <= 1'b0;
        end else begin
            frame_valid <= 1'b0;
            seg_err     <= 1'b0;
            sel_err     <= 1'b0;
            if (w_capture) begin
                if (w_sel_one) begin
                    for (int i = 0; i < 4; i++) begin
                        if (r_s_sel[i]) r_shadow[i] <= w_dec;
                    end
                    seg_err <= (w_dec == 4'hE);
                    if (w_mask_new == 4'hF) begin
                        digit1      <= r_s_sel[0] ? w_dec : r_shadow[0];
                        digit2      <= r_s_sel[1] ? w_dec : r_shadow[1];
                        digit3      <= r_s_sel[2] ? w_dec : r_shadow[2];
                        digit4      <= r_s_sel[3] ? w_dec : r_shadow[3];
                        frame_valid <= 1'b1;
                        r_mask      <= 4'd0;
                    end else begin
                        r_mask <= w_mask_new;
                    end
                end else begin
                    sel_err <= 1'b1;
                end
            end
        end
    end

endmodule
`default_nettype wire

// File: tb/tb_seven_seg_scan_decoder.sv
`default_nettype none
// ============================================================================
// Module      : tb_seven_seg_scan_decoder
// Description : Scoreboard bench for seven_seg_scan_decoder (active-low bus).
// Revision    : 1.0 - initial release
// ============================================================================
module tb_seven_seg_scan_decoder;

    localparam int STABLE = 4;

    logic       clk = 1'b0;
    logic       rst;
    logic [6:0] sevenout;
    logic [3:0] seven_select;
    logic [3:0] digit1, digit2, digit3, digit4;
    logic       frame_valid, seg_err, sel_err;

    int n_err = 0;
    int n_chk = 0;
    int exp_seg_err = 0, got_seg_err = 0;
    int exp_sel_err = 0, got_sel_err = 0;
    logic [15:0] exp_q[$];
    logic [3:0]  m_shadow [4];
    logic [3:0]  m_mask;

    seven_seg_scan_decoder #(
        .STABLE_CYCLES(STABLE),
        .SEG_ACT_LOW  (1'b1),
        .SEL_ACT_LOW  (1'b1)
    ) u_dut (
        .clk         (clk),
        .rst         (rst),
        .sevenout    (sevenout),
        .seven_select(seven_select),
        .digit1      (digit1),
        .digit2      (digit2),
        .digit3      (digit3),
        .digit4      (digit4),
        .frame_valid (frame_valid),
        .seg_err     (seg_err),
        .sel_err     (sel_err)
    );

    always #5 clk = ~clk;

    task automatic check(input string tag, input logic [31:0] act, input logic [31:0] exp);
        n_chk++;
        if (act !== exp) begin
            n_err++;
            $display("FAIL %s: got %0h expected %0h", tag, act, exp);
        end
    endtask

    // Active-low segment pattern for a digit; anything else is blank.
    function automatic logic [6:0] al(input int d);
        case (d)
            0: return 7'h40;  1: return 7'h79;  2: return 7'h24;  3: return 7'h30;
            4: return 7'h19;  5: return 7'h12;  6: return 7'h02;  7: return 7'h78;
            8: return 7'h00;  9: return 7'h10;
            default: return 7'h7F;
        endcase
    endfunction

    function automatic logic [3:0] dec_al(input logic [6:0] raw);
        for (int d = 0; d < 10; d++) if (al(d) == raw) return 4'(d);
        if (raw == 7'h7F) return 4'hF;
        return 4'hE;
    endfunction

    function automatic logic [3:0] pos(input int p);
        logic [3:0] v;
        v = 4'b0001 << p;
        return ~v;
    endfunction

    task automatic model_reset();
        m_mask = 4'd0;
        for (int i = 0; i < 4; i++) m_shadow[i] = 4'hF;
    endtask

    // Drive one dwell of n clocks and predict its effect.
    task automatic dwell(input logic [3:0] sel_raw, input logic [6:0] seg_raw, input int n);
        logic [3:0] act;
        logic [3:0] d;
        act          = ~sel_raw;
        d            = dec_al(seg_raw);
        sevenout     = seg_raw;
        seven_select = sel_raw;
        if (n >= STABLE) begin
            if ($countones(act) == 1) begin
                for (int i = 0; i < 4; i++) if (act[i]) m_shadow[i] = d;
                if (d == 4'hE) exp_seg_err++;
                m_mask = m_mask | act;
                if (m_mask == 4'hF) begin
                    exp_q.push_back({m_shadow[3], m_shadow[2], m_shadow[1], m_shadow[0]});
                    m_mask = 4'd0;
                end
            end else if ($countones(act) > 1) begin
                exp_sel_err++;
            end
        end
        repeat (n) @(negedge clk);
    endtask

    task automatic idle(input int n);
        dwell(4'hF, 7'h7F, n);
    endtask

    task automatic drain(input string tag);
        idle(6);
        check({tag, "_pending"}, exp_q.size(), 0);
        check({tag, "_seg_err"}, got_seg_err, exp_seg_err);
        check({tag, "_sel_err"}, got_sel_err, exp_sel_err);
    endtask

    always @(negedge clk) begin
        if (!rst) begin
            if (frame_valid) begin
                if (exp_q.size() == 0) check("frame_unexpected", 1, 0);
                else check("frame", {digit4, digit3, digit2, digit1}, exp_q.pop_front());
            end
            if (seg_err) got_seg_err++;
            if (sel_err) got_sel_err++;
        end
    end

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    initial begin
        rst          = 1'b1;
        sevenout     = 7'h7F;
        seven_select = 4'hF;
        model_reset();
        repeat (10) @(negedge clk);
        check("rst_digit1", digit1, 4'hF);
        check("rst_digit2", digit2, 4'hF);
        check("rst_digit3", digit3, 4'hF);
        check("rst_digit4", digit4, 4'hF);
        check("rst_frame_valid", frame_valid, 0);
        check("rst_seg_err", seg_err, 0);
        check("rst_sel_err", sel_err, 0);
        rst = 1'b0;

        // Partial frame on digits 3/4, then reset discards it.
        dwell(pos(2), al(1), 8);
        dwell(pos(3), al(2), 8);
        rst = 1'b1;
        model_reset();
        sevenout     = 7'h7F;
        seven_select = 4'hF;
        repeat (3) @(negedge clk);
        check("midrst_digit1", digit1, 4'hF);
        check("midrst_frame_valid", frame_valid, 0);
        rst = 1'b0;
        idle(2);
        dwell(pos(0), al(3), 8);
        dwell(pos(1), al(4), 8);
        dwell(pos(2), al(5), 8);
        check("midrst_no_early_frame", exp_q.size(), 0);
        dwell(pos(3), al(6), 8);
        drain("t1");

        // Basic scan: 9, 0, blank, blank.
        dwell(pos(0), 7'h10, 8);
        dwell(pos(1), 7'h40, 8);
        dwell(pos(2), 7'h7F, 8);
        dwell(pos(3), 7'h7F, 8);
        drain("t2");
        check("t2_digit1", digit1, 4'd9);
        check("t2_digit2", digit2, 4'd0);
        check("t2_digit4", digit4, 4'hF);

        // Short dwell of STABLE-1 must not capture.
        dwell(pos(1), al(8), 8);
        dwell(pos(2), al(1), 8);
        dwell(pos(3), al(2), 8);
        dwell(pos(0), al(5), STABLE - 1);
        dwell(pos(0), al(7), 8);
        drain("t3");

        // All-lit pattern decodes to 8; 7'h55 is illegal.
        dwell(pos(0), al(0), 8);
        dwell(pos(1), 7'h00, 8);
        dwell(pos(2), al(3), 8);
        dwell(pos(3), al(4), 8);
        dwell(pos(1), 7'h55, 8);
        dwell(pos(0), al(1), 8);
        dwell(pos(2), al(2), 8);
        dwell(pos(3), al(3), 8);
        drain("t4");
        check("t4_digit2", digit2, 4'hE);

        // Multi-active select flags an error and leaves the mask alone.
        dwell(pos(0), al(1), 8);
        dwell(pos(1), al(2), 8);
        dwell(pos(2), al(3), 8);
        dwell(4'b1100, al(4), 8);
        check("t5_no_frame", exp_q.size(), 0);
        dwell(pos(3), al(9), 8);
        drain("t5");

        // Repeat capture of one position before the frame completes.
        dwell(pos(0), al(5), 8);
        dwell(pos(0), al(6), 8);
        dwell(pos(1), al(7), 8);
        dwell(pos(2), al(8), 8);
        dwell(pos(3), al(9), 8);
        drain("t6");
        check("t6_digit1", digit1, 4'd6);

        $display("Result: errors=%0d of %0d checks", n_err, n_chk);
        $finish;
    end

endmodule
`default_nettype wire
